corelet_ctrl: RTL



---
 rtl/corelet_ctrl_if.sv | 23 ++
 rtl/corelet_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/corelet_ctrl_if.sv
// Sequencer <-> corelet/host bundle: start/status in, inst bus and flags out.
// master: sequencer side (drives inst, sfp_clr, busy, done, err, kij_o).
interface corelet_ctrl_if;
  logic        start;
  logic        l0_o_full;
  logic        ofifo_valid;
  logic [33:0] inst;
  logic        sfp_clr;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  kij_o;

  modport master (
    input  start, l0_o_full, ofifo_valid,
    output inst, sfp_clr, busy, done, err, kij_o
  );

  modport slave (
    output start, l0_o_full, ofifo_valid,
    input  inst, sfp_clr, busy, done, err, kij_o
  );
endinterface

// File: rtl/corelet_ctrl.sv
// Weight-stationary 3x3 conv tile sequencer driving the corelet inst bus.
// Ports: clk, reset (sync, high), bus (corelet_ctrl_if.master).
module corelet_ctrl #(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int LEN_NIJ  = 36,
  parameter int IN_W     = 6,
  parameter int OUT_W    = 4,
  parameter int K_W      = 3,
  parameter int W_BASE   = 64,
  parameter int OUT_BASE = 1024,
  parameter int L0_DEPTH = 64
) (
  input logic            clk,
  input logic            reset,
  corelet_ctrl_if.master bus
);
  localparam int LEN_ONIJ = OUT_W * OUT_W;
  localparam int LEN_KIJ  = K_W * K_W;
  localparam int CW       = $clog2(L0_DEPTH + 2);
  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  typedef enum logic [3:0] {
    S_IDLE, S_W_XLOAD, S_W_ARRAY, S_W_FLUSH,
    S_A_XLOAD, S_EXEC, S_PSUM, S_ACC_RD,
    S_ACC_WAIT, S_ACC_WR, S_DONE
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [3:0]      r_kij, w_kij;
  logic [4:0]      r_o, w_o;
  logic [33:0]     r_inst, w_inst;
  logic            r_sfp_clr, w_sfp_clr;
  logic            r_busy, r_done;
  logic            r_err, w_err;
  logic            w_pop;
  int              w_xn;

  // r_cnt counts actions issued up to and including the current cycle.
  // Step 1 picks the next state; step 2 issues that state's next action.
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_kij     = r_kij;
    w_o       = r_o;
    w_err     = r_err;
    w_sfp_clr = 1'b0;
    w_inst    = INST_IDLE;
    // l0_wr and acc_q trail the SRAM read by one cycle
    w_inst[2]  = ~r_inst[19] & r_inst[18];
    w_inst[33] = ~r_inst[32] & r_inst[31];

    unique case (r_state)
      S_IDLE: if (bus.start) begin
        w_state = S_W_XLOAD;
        w_cnt   = '0;
        w_kij   = '0;
        w_o     = '0;
      end
      S_W_XLOAD: if (int'(r_cnt) == COL + 1) begin
        w_state = S_W_ARRAY;
        w_cnt   = '0;
      end
      S_W_ARRAY: if (int'(r_cnt) == COL) begin
        w_state = S_W_FLUSH;
        w_cnt   = '0;
      end
      S_W_FLUSH: if (int'(r_cnt) == ROW + COL) begin
        w_state = S_A_XLOAD;
        w_cnt   = '0;
      end
      S_A_XLOAD: if (int'(r_cnt) == LEN_NIJ + 1) begin
        w_state = S_EXEC;
        w_cnt   = '0;
      end
      S_EXEC: if (int'(r_cnt) == LEN_NIJ) begin
        w_state = S_PSUM;
        w_cnt   = '0;
      end
      S_PSUM: if (bus.ofifo_valid) begin
        if (int'(r_cnt) == LEN_NIJ - 1) begin
          w_cnt = '0;
          w_kij = r_kij + 4'd1;
          if (int'(r_kij) == LEN_KIJ - 1) begin
            w_state = S_ACC_RD;
            w_o     = '0;
          end else begin
            w_state = S_W_XLOAD;
          end
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_ACC_RD: if (int'(r_cnt) == LEN_KIJ + 1) begin
        w_state = S_ACC_WAIT;
        w_cnt   = '0;
      end
      S_ACC_WAIT: w_state = S_ACC_WR;
      S_ACC_WR: begin
        w_cnt = '0;
        w_o   = r_o + 5'd1;
        if (int'(r_o) == LEN_ONIJ - 1)
          w_state = S_DONE;
        else
          w_state = S_ACC_RD;
      end
      S_DONE: w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    w_xn = (w_state == S_W_XLOAD) ? COL : LEN_NIJ;

    unique case (w_state)
      S_W_XLOAD, S_A_XLOAD: begin
        if (int'(w_cnt) < w_xn) begin
          if (bus.l0_o_full) begin
            w_err = 1'b1;
          end else begin
            w_inst[19] = 1'b0;
            if (w_state == S_W_XLOAD)
              w_inst[17:7] = 11'(W_BASE
                + int'(w_kij) * COL + int'(w_cnt));
            else
              w_inst[17:7] = 11'(int'(w_cnt));
            w_cnt = w_cnt + CW'(1);
          end
        end else if (int'(w_cnt) == w_xn) begin
          w_cnt = w_cnt + CW'(1);
        end
      end
      S_W_ARRAY: begin
        w_inst[3] = 1'b1;
        w_inst[0] = 1'b1;
        w_cnt     = w_cnt + CW'(1);
      end
      S_W_FLUSH: w_cnt = w_cnt + CW'(1);
      S_EXEC: begin
        w_inst[3] = 1'b1;
        w_inst[1] = 1'b1;
        w_cnt     = w_cnt + CW'(1);
      end
      S_ACC_RD: begin
        if (int'(w_cnt) < LEN_KIJ) begin
          w_inst[32] = 1'b0;
          w_inst[30:20] = 11'(int'(w_cnt) * LEN_NIJ
            + (int'(w_o) / OUT_W + int'(w_cnt) / K_W) * IN_W
            + int'(w_o) % OUT_W + int'(w_cnt) % K_W);
        end
        w_cnt = w_cnt + CW'(1);
      end
      S_ACC_WR: begin
        w_inst[32]    = 1'b0;
        w_inst[31]    = 1'b0;
        w_inst[30:20] = 11'(OUT_BASE + int'(w_o));
        w_sfp_clr     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_kij     <= '0;
      r_o       <= '0;
      r_inst    <= INST_IDLE;
      r_sfp_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_kij     <= w_kij;
      r_o       <= w_o;
      r_inst    <= w_inst;
      r_sfp_clr <= w_sfp_clr;
      r_busy    <= (w_state != S_IDLE);
      r_done    <= (w_state == S_DONE);
      r_err     <= w_err;
    end
  end

  // OFIFO pop and psum write follow ofifo_valid in the same cycle,
  // so this one path is gated combinationally.
  assign w_pop = (r_state == S_PSUM) & bus.ofifo_valid;

  always_comb begin
    bus.inst = r_inst;
    if (w_pop) begin
      bus.inst[6]     = 1'b1;
      bus.inst[32]    = 1'b0;
      bus.inst[31]    = 1'b0;
      bus.inst[30:20] = 11'(int'(r_kij) * LEN_NIJ + int'(r_cnt));
    end
  end

  assign bus.sfp_clr = r_sfp_clr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.kij_o   = r_kij;
endmodule
